// File: rtl/bram18_rd_pkg.sv
// Shared types and defaults for the BRAM18 stream reader: FSM state encoding,
// default geometry of the 1024x18 RAM port, and the command length clamp.
package bram18_rd_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_PAR_W  = 2;
    localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE_ST
    } rd_state_e;

    // A command can never cover more than the whole RAM once.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned addr_w);
        int unsigned depth;
        depth = 32'd1 << addr_w;
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/bram18_stream_reader_skid.sv
// Two-entry FIFO that captures RAM read data and holds it under stream
// backpressure; each entry carries a tag marking the final beat of a command.
module bram_rd_skid
    import bram18_rd_pkg::*;
#(
    parameter int W = DEF_DATA_W + DEF_PAR_W
) (
    input  logic         clk,
    input  logic         ssr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [W:0] mem_q [2];
    logic [W:0] mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ssr) begin
            // NOTE: the storage is cleared on reset because the head entry
            // drives TDATA directly and must read as zero after reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = mem_q[rd_ptr_q][W-1:0];
    assign head_last = mem_q[rd_ptr_q][W];

endmodule

// File: rtl/bram18_stream_reader.sv
// Read-side initiator for one BRAM18 port: sweeps LEN addresses from BASE_ADDR
// and streams {parity, data} on valid/ready, marking the final beat with TLAST.
module bram18_stream_reader
    import bram18_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAR_W  = DEF_PAR_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic                     CLK,
    input  logic                     SSR,
    input  logic                     START,
    input  logic [ADDR_W-1:0]        BASE_ADDR,
    input  logic [LEN_W-1:0]         LEN,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     RAM_EN,
    output logic                     RAM_WE,
    output logic [ADDR_W-1:0]        RAM_ADDR,
    input  logic [DATA_W-1:0]        RAM_DO,
    input  logic [PAR_W-1:0]         RAM_DOP,
    output logic [DATA_W+PAR_W-1:0]  TDATA,
    output logic                     TVALID,
    input  logic                     TREADY,
    output logic                     TLAST
);

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        occ;
    logic              head_last;
    logic              pop;
    logic              issue;
    logic [2:0]        credit_use;
    logic [LEN_W-1:0]  len_eff;

    assign len_eff = LEN_W'(clamp_len(32'(LEN), ADDR_W));

    assign TVALID = (occ != 2'd0);
    assign TLAST  = TVALID & head_last;
    assign pop    = TVALID & TREADY;

    // Words already buffered plus the one returning from the RAM, less the one
    // leaving this cycle, must leave room for a new read in the 2-entry FIFO.
    assign credit_use = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (state_q == RUN) && (remaining_q != '0) && (credit_use < 3'd2);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path through
        // this block can leave a value unassigned and infer a latch.
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue && (remaining_q == LEN_W'(1));
        done_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d      = BASE_ADDR;
                    remaining_d = len_eff;
                    state_d     = (len_eff == '0) ? DONE_ST : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && TLAST) begin
                    state_d = DONE_ST;
                    done_d  = 1'b1;
                end
            end
            DONE_ST: begin
                // Coming from DRAIN the pulse is already up; an empty command
                // arrives here with it still low and raises it one cycle later.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (SSR) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
        end
    end

    bram_rd_skid #(
        .W (DATA_W + PAR_W)
    ) u_skid (
        .clk       (CLK),
        .ssr       (SSR),
        .push      (inflight_q),
        .push_data ({RAM_DOP, RAM_DO}),
        .push_last (inflight_last_q),
        .pop       (pop),
        .occ       (occ),
        .head_data (TDATA),
        .head_last (head_last)
    );

    assign RAM_EN   = issue;
    assign RAM_WE   = 1'b0;
    assign RAM_ADDR = addr_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_bram18_stream_reader.sv
// Directed bench for bram18_stream_reader with a 1-cycle synchronous RAM model.
module tb_bram18_stream_reader;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int PAR_W  = 2;
    localparam int LEN_W  = 11;
    localparam int WORD_W = DATA_W + PAR_W;
    localparam int DEPTH  = 1024;

    logic              CLK = 1'b0;
    logic              SSR;
    logic              START;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [LEN_W-1:0]  LEN;
    logic              BUSY, DONE, RAM_EN, RAM_WE;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic [DATA_W-1:0] RAM_DO;
    logic [PAR_W-1:0]  RAM_DOP;
    logic [WORD_W-1:0] TDATA;
    logic              TVALID, TREADY, TLAST;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ram_q = '0;

    int checks   = 0;
    int failures = 0;
    int cyc = 0, t0 = 0, rmode = 0, pat_idx = 0;

    logic [WORD_W:0]   beats [$];
    int                beat_rel [$];
    logic [ADDR_W-1:0] addrs [$];
    int first_en, en_count, tvalid_count, busy_count, done_count;
    int done_rel, last_rel, out_cnt, credit_viol, stall_viol;
    logic              prev_stall, last_tvalid;
    logic [WORD_W:0]   prev_word;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_EN) ram_q <= mem[RAM_ADDR];
    end
    assign RAM_DO  = ram_q[DATA_W-1:0];
    assign RAM_DOP = ram_q[WORD_W-1:DATA_W];

    bram18_stream_reader dut (
        .CLK       (CLK),
        .SSR       (SSR),
        .START     (START),
        .BASE_ADDR (BASE_ADDR),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .RAM_EN    (RAM_EN),
        .RAM_WE    (RAM_WE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_DO    (RAM_DO),
        .RAM_DOP   (RAM_DOP),
        .TDATA     (TDATA),
        .TVALID    (TVALID),
        .TREADY    (TREADY),
        .TLAST     (TLAST)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] exp_word(input int a);
        logic [15:0] d;
        d = 16'(a % DEPTH) + 16'h0100;
        return {2'b01, d};
    endfunction

    task automatic clear_rec();
        beats.delete();
        beat_rel.delete();
        addrs.delete();
        first_en = -1;
        en_count = 0; tvalid_count = 0; busy_count = 0; done_count = 0;
        done_rel = -1; last_rel = -1; out_cnt = 0;
        credit_viol = 0; stall_viol = 0;
        prev_stall = 1'b0; prev_word = '0; last_tvalid = 1'b0;
    endtask

    task automatic sample();
        int rel;
        rel = cyc - t0;
        last_tvalid = TVALID;
        if (SSR) begin
            out_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (RAM_EN) begin
                en_count++;
                addrs.push_back(RAM_ADDR);
                if (first_en < 0) first_en = rel;
                out_cnt++;
            end
            if (TVALID) tvalid_count++;
            if (TVALID && TREADY) begin
                beats.push_back({TLAST, TDATA});
                beat_rel.push_back(rel);
                out_cnt--;
                if (TLAST) last_rel = rel;
            end
            if (out_cnt > 2) credit_viol++;
            if (prev_stall && (!TVALID || ({TLAST, TDATA} != prev_word))) stall_viol++;
            prev_stall = TVALID && !TREADY;
            prev_word  = {TLAST, TDATA};
            if (BUSY) busy_count++;
            if (DONE) begin
                done_count++;
                done_rel = rel;
            end
        end
    endtask

    // One clock: drive TREADY, sample on the falling edge, return just after the rising edge.
    task automatic step();
        TREADY = (rmode == 0) ? 1'b1 : ((pat_idx % 3) == 0);
        pat_idx++;
        @(negedge CLK);
        sample();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run_cmd(input string tag, input int base, input int len,
                           input int mode, input bit inject);
        int n;
        clear_rec();
        rmode     = mode;
        pat_idx   = 0;
        t0        = cyc;
        START     = 1'b1;
        BASE_ADDR = ADDR_W'(base);
        LEN       = LEN_W'(len);
        step();
        START = 1'b0;
        n = 0;
        while (done_count == 0 && n < 3000) begin
            if (inject && n == 1) begin
                START     = 1'b1;
                BASE_ADDR = 10'd900;
                LEN       = 11'd3;
            end else begin
                START = 1'b0;
            end
            step();
            n++;
        end
        START = 1'b0;
        repeat (3) step();
        check({tag, "_done_pulses"}, done_count, 1);
    endtask

    task automatic verify(input string tag, input int base, input int n);
        int bad;
        int lim;
        bad = 0;
        check({tag, "_beats"}, beats.size(), n);
        check({tag, "_reads"}, addrs.size(), n);
        lim = (beats.size() < n) ? beats.size() : n;
        for (int i = 0; i < lim; i++) begin
            if (n <= 16) begin
                check({tag, "_data"}, beats[i][WORD_W-1:0], exp_word(base + i));
                check({tag, "_last"}, beats[i][WORD_W], (i == n - 1));
            end else if ((beats[i][WORD_W-1:0] != exp_word(base + i)) ||
                         (beats[i][WORD_W] != (i == n - 1))) begin
                bad++;
            end
        end
        lim = (addrs.size() < n) ? addrs.size() : n;
        for (int i = 0; i < lim; i++) begin
            if (n <= 16) begin
                check({tag, "_addr"}, addrs[i], (base + i) % DEPTH);
            end else if (addrs[i] != ADDR_W'((base + i) % DEPTH)) begin
                bad++;
            end
        end
        if (n > 16) check({tag, "_bad_items"}, bad, 0);
    endtask

    initial begin
        int n;
        for (int a = 0; a < DEPTH; a++) mem[a] = exp_word(a);
        SSR = 1'b1; START = 1'b0; TREADY = 1'b1;
        BASE_ADDR = '0; LEN = '0;
        clear_rec();

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy",   BUSY,     0);
        check("rst_done",   DONE,     0);
        check("rst_ram_en", RAM_EN,   0);
        check("rst_ram_we", RAM_WE,   0);
        check("rst_addr",   RAM_ADDR, 0);
        check("rst_tvalid", TVALID,   0);
        check("rst_tlast",  TLAST,    0);
        check("rst_tdata",  TDATA,    0);
        @(posedge CLK);
        #1;
        SSR = 1'b0;
        repeat (2) step();

        // Basic sweep: latency and full throughput.
        run_cmd("t1", 5, 4, 0, 1'b0);
        verify("t1", 5, 4);
        check("t1_first_en", first_en, 1);
        for (int i = 0; i < beat_rel.size(); i++) check("t1_beat_cycle", beat_rel[i], 3 + i);
        check("t1_tlast_cycle", last_rel, 6);
        check("t1_done_cycle",  done_rel, 7);
        check("t1_busy_cycles", busy_count, 7);

        // Address wrap 1023 -> 0.
        run_cmd("t2", 1022, 4, 0, 1'b0);
        verify("t2", 1022, 4);

        // Backpressure with TREADY pattern 1,0,0.
        run_cmd("t3", 100, 8, 1, 1'b0);
        verify("t3", 100, 8);
        check("t3_stall_stable", stall_viol, 0);
        check("t3_credit", credit_viol, 0);

        // Zero length.
        run_cmd("t4", 33, 0, 0, 1'b0);
        check("t4_ram_en", en_count, 0);
        check("t4_tvalid", tvalid_count, 0);
        check("t4_done_cycle", done_rel, 2);
        check("t4_busy_cycles", busy_count, 2);

        // Over-long command is clamped to the RAM depth.
        run_cmd("t5", 7, 1500, 0, 1'b0);
        verify("t5", 7, 1024);
        check("t5_credit", credit_viol, 0);

        // Reset in the middle of a command while a beat is pending.
        clear_rec();
        rmode = 1; pat_idx = 0; t0 = cyc;
        START = 1'b1; BASE_ADDR = 10'd50; LEN = 11'd16;
        step();
        START = 1'b0;
        n = 0;
        while (!(last_tvalid && n >= 4) && n < 20) begin
            step();
            n++;
        end
        SSR = 1'b1;
        step();
        SSR = 1'b0;
        check("t6_tvalid_at_reset", last_tvalid, 1);
        clear_rec();
        repeat (6) step();
        check("t6_tvalid_after", tvalid_count, 0);
        check("t6_ram_en_after", en_count, 0);
        check("t6_busy_after", busy_count, 0);
        check("t6_done_after", done_count, 0);
        run_cmd("t6b", 0, 2, 0, 1'b0);
        verify("t6b", 0, 2);

        // START during RUN is ignored.
        run_cmd("t7", 200, 6, 0, 1'b1);
        verify("t7", 200, 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram18_stream_reader.md
Name: bram18_stream_reader

Overview:
- Read-side initiator for one port of the 1024x18 dual-port block RAM (16 data bits + 2 parity bits, 1-cycle synchronous read).
- On a START command, sweeps LEN consecutive addresses from BASE_ADDR and emits each word on a valid/ready stream, with TLAST on the final beat.
- Sits between the RAM port and downstream consumers (packetisers, DMA out); the other RAM port is the writer.
- Fully absorbs RAM read latency and downstream backpressure without losing or duplicating words.

Parameters:
ADDR_W, 10, RAM address width (depth 2**ADDR_W)
DATA_W, 16, RAM data width
PAR_W, 2, RAM parity width
LEN_W, 11, command length width (must be ADDR_W+1)

Ports:
CLK  in  1  single clock for block and RAM port
SSR  in  1  synchronous active-high reset
START  in  1  command strobe, sampled only in IDLE
BASE_ADDR  in  ADDR_W  first address, sampled with START
LEN  in  LEN_W  beat count, sampled with START
BUSY  out  1  high from the cycle after START is accepted until DONE
DONE  out  1  one-cycle pulse after the last beat is accepted
RAM_EN  out  1  RAM port enable (read issue)
RAM_WE  out  1  RAM write enable, constant 0
RAM_ADDR  out  ADDR_W  RAM port address
RAM_DO  in  DATA_W  RAM read data, valid the cycle after RAM_EN
RAM_DOP  in  PAR_W  RAM read parity, same timing as RAM_DO
TDATA  out  DATA_W+PAR_W  {RAM_DOP, RAM_DO}
TVALID  out  1  stream valid
TREADY  in  1  stream ready
TLAST  out  1  qualifies the final beat of the command

Behaviour:
- Reset (SSR=1 at a CLK edge): state IDLE; BUSY=0, DONE=0, RAM_EN=0, RAM_WE=0, RAM_ADDR=0, TVALID=0, TLAST=0, TDATA=0; buffer emptied; in-flight read discarded. Reset mid-command aborts it: no DONE, and no further beats.
- FSM states:
  - IDLE: if START=1, latch BASE_ADDR and the effective length, then go to RUN. An effective length of 0 goes directly to DONE_ST.
  - RUN: issue reads. After the last read is issued, go to DRAIN.
  - DRAIN: wait until the last beat is accepted (TVALID & TREADY & TLAST), then go to DONE_ST.
  - DONE_ST: DONE=1 for exactly one cycle, then IDLE.
- START outside IDLE is ignored.
- Length rules: LEN=0 produces no beats and DONE two cycles after START. LEN>2**ADDR_W is clamped to 2**ADDR_W.
- Addressing: beat i reads (BASE_ADDR+i) mod 2**ADDR_W, wrapping 1023->0.
- Read issue: RAM_EN=1 in a cycle iff state=RUN, remaining!=0, and (occ + inflight - pop) < 2, where:
  - occ is buffer occupancy (0..2);
  - inflight is 1 if RAM_EN was high in the previous cycle;
  - pop = TVALID & TREADY.
  - RAM_ADDR advances only on issue.
- Capture: the cycle after an issue, {RAM_DOP,RAM_DO} is written into a 2-entry FIFO with a tag bit set on the final beat. The FIFO head drives TDATA/TLAST, and TVALID = occ!=0.
- Latency: START high in cycle 0 -> first RAM_EN in cycle 1 -> first TVALID in cycle 3.
- Throughput: 1 beat/cycle while TREADY=1.
- Backpressure:
  - TDATA/TLAST are stable while TVALID=1 and TREADY=0.
  - A word is never overwritten or dropped.
  - Simultaneous push and pop with occ=2 is impossible by the credit rule; the bench asserts this.
- TLAST=1 only on beat LEN-1. BUSY=1 in RUN, DRAIN and DONE_ST.

Decomposition:
- Package bram18_rd_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE_ST};
  - constants ADDR_W/DATA_W/PAR_W defaults;
  - function clamp_len.
- Sub-module bram_rd_skid: 2-entry synchronous FIFO with push/pop/occ and a last-tag bit, reset by SSR. The top level holds the FSM, address/remaining counters and credit logic.

Test Plan:
- RAM preloaded with word[a]={2'b01,a[9:0]+16'h100}; BASE=5, LEN=4, TREADY=1 -> TDATA 0x10105,0x10106,0x10107,0x10108 in cycles 3-6; TLAST in cycle 6; DONE in cycle 7.
- BASE=1022, LEN=4 -> addresses 1022,1023,0,1 in order; data matches; TLAST on the 4th beat.
- LEN=8 with TREADY toggling 1,0,0,1,...
  - Required: exactly 8 beats, in order, no duplicates.
  - Required: TDATA stable during stalls; RAM_EN never makes occ+inflight exceed 2.
- LEN=0 -> no RAM_EN, no TVALID, DONE pulse in cycle 2. LEN=1500 -> exactly 1024 beats, TLAST on beat 1023.
- SSR asserted in the middle of a LEN=16 command while TVALID=1:
  - Next cycle: TVALID=0, BUSY=0, RAM_EN=0, and no DONE.
  - A new START with BASE=0, LEN=2 then produces words 0 and 1 only.
- START pulsed again during RUN with different BASE/LEN -> ignored; the original command completes unchanged.
